// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, start/done handshake.
// The final iteration writes the corrected result, so the FIN cycle is the done cycle.
module cpu_muldiv #(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            op_sel,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  z_flag
);
    localparam int W = DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [W-1:0]         opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2*W-1:0]       acc_q, acc_d;     // product, or {remainder, quotient}
    logic [W-1:0]         result_q, result_d;

    // Operand decode at start
    logic         a_signed, b_signed, sign_a, sign_b, is_div, special;
    logic [W-1:0] mag_a, mag_b, special_val;

    always_comb begin
        is_div   = op_sel[2];
        a_signed = (op_sel == OP_MULH) || (op_sel == OP_MULHSU) ||
                   (op_sel == OP_DIV)  || (op_sel == OP_REM);
        b_signed = (op_sel == OP_MULH) || (op_sel == OP_DIV) || (op_sel == OP_REM);
        sign_a   = a_signed & in_a[W-1];
        sign_b   = b_signed & in_b[W-1];
        mag_a    = sign_a ? -in_a : in_a;
        mag_b    = sign_b ? -in_b : in_b;
        special     = 1'b0;
        special_val = '0;
        if (is_div && (in_b == '0)) begin
            special     = 1'b1;
            special_val = op_sel[1] ? in_a : '1;
        end else if (is_div && !op_sel[0] && (in_a == MOST_NEG) && (in_b == '1)) begin
            special     = 1'b1;
            special_val = op_sel[1] ? '0 : in_a;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    logic [W:0]     mul_sum, div_top, div_diff;
    logic           div_ge;
    logic [2*W-1:0] step, prod;
    logic [W-1:0]   div_sel, fin_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_top  = acc_q[2*W-1:W-1];
        div_diff = div_top - {1'b0, opnd_q};
        div_ge   = ~div_diff[W];
        if (op_q[2]) begin
            step = {(div_ge ? div_diff[W-1:0] : div_top[W-1:0]), acc_q[W-2:0], div_ge};
        end else begin
            step = {mul_sum, acc_q[W-1:1]};
        end
        prod    = neg_q ? -step : step;
        div_sel = op_q[1] ? step[2*W-1:W] : step[W-1:0];
        if (op_q[2]) begin
            fin_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == OP_MUL) begin
            fin_res = prod[W-1:0];
        end else begin
            fin_res = prod[2*W-1:W];
        end
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d  = op_sel;
                    neg_d = (op_sel[2] && op_sel[1]) ? sign_a : (sign_a ^ sign_b);
                    if (special) begin
                        result_d = special_val;
                        state_d  = S_FIN;
                    end else begin
                        opnd_d  = is_div ? mag_b : mag_a;
                        acc_d   = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                        cnt_d   = CNT_WIDTH'(W);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        result_d = fin_res;
                        state_d  = S_FIN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_FIN);
    assign result = result_q;
    assign z_flag = (result_q == '0);

`ifdef DESIGNER_ASSERTIONS
    a_no_x:  assert property (@(posedge clk) disable iff (rst) !$isunknown({busy, done, result}));
    a_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_excl:  assert property (@(posedge clk) !(busy && done));
    a_zflag: assert property (@(posedge clk) z_flag === (result === '0));
`endif
endmodule
